// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline stage: default widths, the
// architectural zero register, control-bundle field offsets and a
// forwarding-source encoding used by the operand mux.
package id_ex_stage_pkg;

   localparam int DATA_W_DEF      = 32;
   localparam int CTRL_W_DEF      = 8;
   localparam int STALL_CNT_W_DEF = 16;
   localparam int REG_ADDR_W      = 5;

   localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

   // Field offsets inside the opaque control bundle (consumed downstream).
   localparam int CTRL_ALU_OP_LSB  = 0;
   localparam int CTRL_ALU_OP_W    = 4;
   localparam int CTRL_USE_IMM_BIT = 4;
   localparam int CTRL_BRANCH_BIT  = 5;
   localparam int CTRL_JUMP_BIT    = 6;
   localparam int CTRL_STORE_BIT   = 7;

   typedef enum logic [1:0] {
      FWD_ZERO = 2'd0,
      FWD_EX   = 2'd1,
      FWD_MEM  = 2'd2,
      FWD_RF   = 2'd3
   } fwd_sel_e;

   // Register r0 is hardwired to zero and never creates a dependency.
   function automatic logic is_zero_reg(input logic [REG_ADDR_W-1:0] r);
      return (r == REG_ZERO);
   endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding mux for one source register. Youngest producer wins:
// the ALU result sitting in EX, then the MEM-stage result, then the bank.
// Loads in EX are excluded because their data does not exist yet; the
// hazard logic stalls instead. WB needs no path because the bank writes on
// the falling edge and its read data is already current.
module fwd_mux
   import id_ex_stage_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic [REG_ADDR_W-1:0] rs_i,
   input  logic [DATA_W-1:0]     rf_data_i,
   input  logic                  ex_valid_i,
   input  logic                  ex_wr_i,
   input  logic                  ex_load_i,
   input  logic [REG_ADDR_W-1:0] ex_rd_i,
   input  logic [DATA_W-1:0]     ex_result_i,
   input  logic                  mem_wr_i,
   input  logic [REG_ADDR_W-1:0] mem_rd_i,
   input  logic [DATA_W-1:0]     mem_data_i,
   output logic [DATA_W-1:0]     op_o
);

   fwd_sel_e sel_s;

   // Pick the forwarding source by producer priority.
   always_comb begin
      sel_s = FWD_RF;
      if (is_zero_reg(rs_i)) begin
         sel_s = FWD_ZERO;
      end else if (ex_valid_i && ex_wr_i && !ex_load_i && (ex_rd_i == rs_i)) begin
         sel_s = FWD_EX;
      end else if (mem_wr_i && (mem_rd_i == rs_i)) begin
         sel_s = FWD_MEM;
      end else begin
         sel_s = FWD_RF;
      end
   end

   // Route the selected source onto the operand.
   always_comb begin
      op_o = rf_data_i;
      case (sel_s)
         FWD_ZERO: op_o = {DATA_W{1'b0}};
         FWD_EX:   op_o = ex_result_i;
         FWD_MEM:  op_o = mem_data_i;
         FWD_RF:   op_o = rf_data_i;
         default:  op_o = rf_data_i;
      endcase
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, one-cycle load-use
// stall (bubble insertion), flush squashing and a saturating stall counter.
module id_ex_stage
   import id_ex_stage_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CTRL_W = CTRL_W_DEF,
   parameter int CNT_W  = STALL_CNT_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic [DATA_W-1:0]     id_imm,
   input  logic [CTRL_W-1:0]     id_ctrl,
   input  logic                  id_wr,
   input  logic                  id_load,
   output logic [REG_ADDR_W-1:0] rf_rs1,
   output logic [REG_ADDR_W-1:0] rf_rs2,
   input  logic [DATA_W-1:0]     rf_r1,
   input  logic [DATA_W-1:0]     rf_r2,
   input  logic                  mem_wr,
   input  logic [REG_ADDR_W-1:0] mem_rd,
   input  logic [DATA_W-1:0]     mem_data,
   input  logic [DATA_W-1:0]     ex_result,
   input  logic                  flush,
   output logic                  id_stall,
   output logic                  ex_valid,
   output logic                  ex_wr,
   output logic                  ex_load,
   output logic [REG_ADDR_W-1:0] ex_rd,
   output logic [DATA_W-1:0]     ex_op1,
   output logic [DATA_W-1:0]     ex_op2,
   output logic [DATA_W-1:0]     ex_imm,
   output logic [CTRL_W-1:0]     ex_ctrl,
   output logic [CNT_W-1:0]      stall_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic                  ex_valid_q, ex_valid_d;
   logic                  ex_wr_q,    ex_wr_d;
   logic                  ex_load_q,  ex_load_d;
   logic [REG_ADDR_W-1:0] ex_rd_q,    ex_rd_d;
   logic [DATA_W-1:0]     ex_op1_q,   ex_op1_d;
   logic [DATA_W-1:0]     ex_op2_q,   ex_op2_d;
   logic [DATA_W-1:0]     ex_imm_q,   ex_imm_d;
   logic [CTRL_W-1:0]     ex_ctrl_q,  ex_ctrl_d;
   logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;

   logic [DATA_W-1:0]     fwd_op1_s;
   logic [DATA_W-1:0]     fwd_op2_s;
   logic                  hazard_s;
   logic                  id_stall_s;

   assign rf_rs1 = id_rs1;
   assign rf_rs2 = id_rs2;

   fwd_mux #(.DATA_W(DATA_W)) u_fwd_rs1 (
      .rs_i        (id_rs1),
      .rf_data_i   (rf_r1),
      .ex_valid_i  (ex_valid_q),
      .ex_wr_i     (ex_wr_q),
      .ex_load_i   (ex_load_q),
      .ex_rd_i     (ex_rd_q),
      .ex_result_i (ex_result),
      .mem_wr_i    (mem_wr),
      .mem_rd_i    (mem_rd),
      .mem_data_i  (mem_data),
      .op_o        (fwd_op1_s)
   );

   fwd_mux #(.DATA_W(DATA_W)) u_fwd_rs2 (
      .rs_i        (id_rs2),
      .rf_data_i   (rf_r2),
      .ex_valid_i  (ex_valid_q),
      .ex_wr_i     (ex_wr_q),
      .ex_load_i   (ex_load_q),
      .ex_rd_i     (ex_rd_q),
      .ex_result_i (ex_result),
      .mem_wr_i    (mem_wr),
      .mem_rd_i    (mem_rd),
      .mem_data_i  (mem_data),
      .op_o        (fwd_op2_s)
   );

   // Load-use detection: a valid ID instruction reads the rd of a load in EX.
   always_comb begin
      hazard_s = 1'b0;
      if (id_valid && ex_valid_q && ex_load_q && !is_zero_reg(ex_rd_q)) begin
         hazard_s = (ex_rd_q == id_rs1) || (ex_rd_q == id_rs2);
      end else begin
         hazard_s = 1'b0;
      end
   end

   // A flushed instruction is squashed, so it never needs to wait.
   assign id_stall_s = hazard_s && !flush;
   assign id_stall   = id_stall_s;

   // Next EX contents: squash on flush, bubble on stall, else capture ID.
   always_comb begin
      ex_valid_d = ex_valid_q;
      ex_wr_d    = ex_wr_q;
      ex_load_d  = ex_load_q;
      ex_rd_d    = ex_rd_q;
      ex_op1_d   = ex_op1_q;
      ex_op2_d   = ex_op2_q;
      ex_imm_d   = ex_imm_q;
      ex_ctrl_d  = ex_ctrl_q;
      if (flush) begin
         ex_valid_d = 1'b0;
         ex_wr_d    = 1'b0;
         ex_load_d  = 1'b0;
      end else if (id_stall_s) begin
         ex_valid_d = 1'b0;
         ex_wr_d    = 1'b0;
         ex_load_d  = 1'b0;
      end else begin
         ex_valid_d = id_valid;
         ex_wr_d    = id_wr && id_valid;
         ex_load_d  = id_load && id_valid;
         ex_rd_d    = id_rd;
         ex_op1_d   = fwd_op1_s;
         ex_op2_d   = fwd_op2_s;
         ex_imm_d   = id_imm;
         ex_ctrl_d  = id_ctrl;
      end
   end

   // Saturating count of cycles spent stalled.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (id_stall_s && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + CNT_ONE;
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   // Pipeline and counter state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid_q  <= 1'b0;
         ex_wr_q     <= 1'b0;
         ex_load_q   <= 1'b0;
         ex_rd_q     <= {REG_ADDR_W{1'b0}};
         ex_op1_q    <= {DATA_W{1'b0}};
         ex_op2_q    <= {DATA_W{1'b0}};
         ex_imm_q    <= {DATA_W{1'b0}};
         ex_ctrl_q   <= {CTRL_W{1'b0}};
         stall_cnt_q <= {CNT_W{1'b0}};
      end else begin
         ex_valid_q  <= ex_valid_d;
         ex_wr_q     <= ex_wr_d;
         ex_load_q   <= ex_load_d;
         ex_rd_q     <= ex_rd_d;
         ex_op1_q    <= ex_op1_d;
         ex_op2_q    <= ex_op2_d;
         ex_imm_q    <= ex_imm_d;
         ex_ctrl_q   <= ex_ctrl_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign ex_valid  = ex_valid_q;
   assign ex_wr     = ex_wr_q;
   assign ex_load   = ex_load_q;
   assign ex_rd     = ex_rd_q;
   assign ex_op1    = ex_op1_q;
   assign ex_op2    = ex_op2_q;
   assign ex_imm    = ex_imm_q;
   assign ex_ctrl   = ex_ctrl_q;
   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage. A second instance with a 4-bit stall
// counter shares all inputs so counter saturation is reached quickly.
module tb_id_ex_stage;

   localparam int DW = 32;
   localparam int CW = 8;

   logic          clk;
   logic          rst_n;
   logic          id_valid;
   logic [4:0]    id_rs1, id_rs2, id_rd;
   logic [DW-1:0] id_imm;
   logic [CW-1:0] id_ctrl;
   logic          id_wr, id_load;
   logic [DW-1:0] rf_r1, rf_r2;
   logic          mem_wr;
   logic [4:0]    mem_rd;
   logic [DW-1:0] mem_data;
   logic [DW-1:0] ex_result;
   logic          flush;

   logic [4:0]    rf_rs1, rf_rs2, ex_rd;
   logic          id_stall, ex_valid, ex_wr, ex_load;
   logic [DW-1:0] ex_op1, ex_op2, ex_imm;
   logic [CW-1:0] ex_ctrl;
   logic [15:0]   stall_cnt;

   logic [4:0]    s_rf_rs1, s_rf_rs2, s_ex_rd;
   logic          s_id_stall, s_ex_valid, s_ex_wr, s_ex_load;
   logic [DW-1:0] s_ex_op1, s_ex_op2, s_ex_imm;
   logic [CW-1:0] s_ex_ctrl;
   logic [3:0]    s_stall_cnt;

   int total = 0;
   int bad   = 0;

   // Reference model: contents of the EX slot as an instruction record.
   logic          m_valid, m_wr, m_load, m_dchk, m_last_stall;
   logic [4:0]    m_rd;
   logic [DW-1:0] m_op1, m_op2, m_imm;
   logic [CW-1:0] m_ctrl;
   int            m_cnt;

   id_ex_stage dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rd(id_rd), .id_imm(id_imm), .id_ctrl(id_ctrl), .id_wr(id_wr), .id_load(id_load),
      .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_r1(rf_r1), .rf_r2(rf_r2), .mem_wr(mem_wr),
      .mem_rd(mem_rd), .mem_data(mem_data), .ex_result(ex_result), .flush(flush),
      .id_stall(id_stall), .ex_valid(ex_valid), .ex_wr(ex_wr), .ex_load(ex_load),
      .ex_rd(ex_rd), .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl),
      .stall_cnt(stall_cnt)
   );

   id_ex_stage #(.CNT_W(4)) dut_small (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rd(id_rd), .id_imm(id_imm), .id_ctrl(id_ctrl), .id_wr(id_wr), .id_load(id_load),
      .rf_rs1(s_rf_rs1), .rf_rs2(s_rf_rs2), .rf_r1(rf_r1), .rf_r2(rf_r2), .mem_wr(mem_wr),
      .mem_rd(mem_rd), .mem_data(mem_data), .ex_result(ex_result), .flush(flush),
      .id_stall(s_id_stall), .ex_valid(s_ex_valid), .ex_wr(s_ex_wr), .ex_load(s_ex_load),
      .ex_rd(s_ex_rd), .ex_op1(s_ex_op1), .ex_op2(s_ex_op2), .ex_imm(s_ex_imm),
      .ex_ctrl(s_ex_ctrl), .stall_cnt(s_stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Value an ID source register should read, from the architectural rules.
   function automatic logic [DW-1:0] src_val(input logic [4:0] rs, input logic [DW-1:0] bank);
      if (rs == 5'd0) return 32'd0;
      if (m_valid && m_wr && !m_load && m_rd == rs) return ex_result;
      if (mem_wr && mem_rd == rs) return mem_data;
      return bank;
   endfunction

   function automatic logic exp_stall();
      logic dep;
      dep = m_valid && m_load && (m_rd != 5'd0) && (m_rd == id_rs1 || m_rd == id_rs2);
      return id_valid && dep && !flush;
   endfunction

   task automatic model_reset();
      m_valid = 1'b0; m_wr = 1'b0; m_load = 1'b0; m_rd = 5'd0;
      m_op1 = 32'd0; m_op2 = 32'd0; m_imm = 32'd0; m_ctrl = 8'd0;
      m_dchk = 1'b1; m_cnt = 0; m_last_stall = 1'b0;
   endtask

   task automatic check_outputs();
      int c16, c4;
      c16 = (m_cnt > 65535) ? 65535 : m_cnt;
      c4  = (m_cnt > 15) ? 15 : m_cnt;
      chk("ex_valid", 32'(ex_valid), 32'(m_valid));
      chk("ex_wr", 32'(ex_wr), 32'(m_wr));
      chk("ex_load", 32'(ex_load), 32'(m_load));
      chk("stall_cnt", 32'(stall_cnt), 32'(c16));
      chk("s_ex_valid", 32'(s_ex_valid), 32'(m_valid));
      chk("s_ex_wr", 32'(s_ex_wr), 32'(m_wr));
      chk("s_ex_load", 32'(s_ex_load), 32'(m_load));
      chk("s_stall_cnt_sat", 32'(s_stall_cnt), 32'(c4));
      if (m_dchk) begin
         chk("ex_rd", 32'(ex_rd), 32'(m_rd));
         chk("ex_op1", ex_op1, m_op1);
         chk("ex_op2", ex_op2, m_op2);
         chk("ex_imm", ex_imm, m_imm);
         chk("ex_ctrl", 32'(ex_ctrl), 32'(m_ctrl));
         chk("s_ex_rd", 32'(s_ex_rd), 32'(m_rd));
         chk("s_ex_op1", s_ex_op1, m_op1);
         chk("s_ex_op2", s_ex_op2, m_op2);
         chk("s_ex_imm", s_ex_imm, m_imm);
         chk("s_ex_ctrl", 32'(s_ex_ctrl), 32'(m_ctrl));
      end
   endtask

   // One clock: check combinational outputs, predict, clock, check registers.
   task automatic cycle();
      logic st;
      logic nv, nw, nl, nd;
      logic [4:0] nrd;
      logic [DW-1:0] no1, no2, nimm;
      logic [CW-1:0] nctl;
      #1;
      st = exp_stall();
      chk("rf_rs1", 32'(rf_rs1), 32'(id_rs1));
      chk("rf_rs2", 32'(rf_rs2), 32'(id_rs2));
      chk("s_rf_rs1", 32'(s_rf_rs1), 32'(id_rs1));
      chk("s_rf_rs2", 32'(s_rf_rs2), 32'(id_rs2));
      chk("id_stall", 32'(id_stall), 32'(st));
      chk("s_id_stall", 32'(s_id_stall), 32'(st));
      nrd = m_rd; no1 = m_op1; no2 = m_op2; nimm = m_imm; nctl = m_ctrl;
      if (flush || st) begin
         nv = 1'b0; nw = 1'b0; nl = 1'b0; nd = 1'b0;
      end else begin
         nv = id_valid; nw = id_wr & id_valid; nl = id_load & id_valid; nd = 1'b1;
         nrd = id_rd; no1 = src_val(id_rs1, rf_r1); no2 = src_val(id_rs2, rf_r2);
         nimm = id_imm; nctl = id_ctrl;
      end
      @(posedge clk);
      #1;
      m_valid = nv; m_wr = nw; m_load = nl; m_dchk = nd; m_rd = nrd;
      m_op1 = no1; m_op2 = no2; m_imm = nimm; m_ctrl = nctl;
      if (st) m_cnt++;
      m_last_stall = st;
      check_outputs();
   endtask

   task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic wr, input logic ld);
      id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_wr = wr; id_load = ld;
      id_imm = $urandom; id_ctrl = 8'($urandom);
      rf_r1 = $urandom; rf_r2 = $urandom;
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; mem_wr = 1'b0; mem_rd = 5'd0; mem_data = 32'd0;
      ex_result = 32'd0;
      set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      model_reset();
      #12;
      check_outputs();
      @(negedge clk);
      rst_n = 1'b1;

      // EX-to-ID forwarding of an ALU result into both operands.
      set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
      cycle();
      set_id(1'b1, 5'd3, 5'd3, 5'd4, 1'b1, 1'b0);
      ex_result = 32'h10;
      cycle();
      chk("fwd_ex_op1", ex_op1, 32'h10);
      chk("fwd_ex_op2", ex_op2, 32'h10);

      // Load-use: one stall, bubble, then MEM forwards the load data.
      set_id(1'b1, 5'd6, 5'd7, 5'd5, 1'b1, 1'b1);
      cycle();
      set_id(1'b1, 5'd5, 5'd9, 5'd8, 1'b1, 1'b0);
      cycle();
      chk("lu_bubble", 32'(ex_valid), 32'd0);
      mem_wr = 1'b1; mem_rd = 5'd5; mem_data = 32'hABCD;
      cycle();
      chk("lu_mem_fwd", ex_op1, 32'hABCD);
      chk("lu_cnt", 32'(stall_cnt), 32'd1);
      mem_wr = 1'b0;

      // r0 never forwards and never stalls.
      set_id(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0);
      cycle();
      ex_result = 32'h55;
      set_id(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
      cycle();
      chk("r0_op1", ex_op1, 32'd0);
      set_id(1'b1, 5'd0, 5'd0, 5'd2, 1'b1, 1'b0);
      cycle();
      chk("r0_load_nostall", 32'(ex_valid), 32'd1);

      // EX has priority over MEM for the same register.
      set_id(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0);
      cycle();
      ex_result = 32'h1; mem_wr = 1'b1; mem_rd = 5'd7; mem_data = 32'h2;
      set_id(1'b1, 5'd7, 5'd0, 5'd9, 1'b1, 1'b0);
      cycle();
      chk("prio_ex_over_mem", ex_op1, 32'h1);
      mem_wr = 1'b0;

      // Flush in the same cycle as a load-use hazard suppresses the stall.
      set_id(1'b1, 5'd1, 5'd2, 5'd6, 1'b1, 1'b1);
      cycle();
      set_id(1'b1, 5'd6, 5'd6, 5'd3, 1'b1, 1'b0);
      flush = 1'b1;
      cycle();
      chk("flush_valid", 32'(ex_valid), 32'd0);
      chk("flush_cnt", 32'(stall_cnt), 32'd1);
      flush = 1'b0;

      // Randomized traffic; the upstream re-presents a stalled instruction.
      for (int i = 0; i < 400; i++) begin
         if (!m_last_stall) begin
            set_id(1'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom_range(0, 2) == 0));
         end
         flush = ($urandom_range(0, 9) == 0);
         mem_wr = 1'($urandom); mem_rd = 5'($urandom_range(0, 7)); mem_data = $urandom;
         ex_result = $urandom;
         cycle();
      end
      flush = 1'b0;

      // Asynchronous reset in mid-cycle while EX holds a valid instruction.
      set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b1);
      cycle();
      chk("pre_reset_valid", 32'(ex_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs();
      set_id(1'b1, 5'd5, 5'd5, 5'd4, 1'b1, 1'b0);
      mem_wr = 1'b0;
      #1;
      rst_n = 1'b1;
      cycle();
      chk("post_reset_capture", 32'(ex_valid), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
